// File: rtl/lgn_pixel_loader.sv
// Pixel-stream front end for the logic-gate-network classifier: thermometer-codes
// each pixel, packs two per byte for the shift-in port, then times the settle window.
module lgn_pixel_loader #(
  parameter int PIXELS        = 256,
  parameter int T0            = 51,
  parameter int T1            = 102,
  parameter int T2            = 153,
  parameter int T3            = 204,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_pix_data,
  input  logic       i_pix_valid,
  output logic       o_pix_ready,
  output logic [7:0] o_byte_out,
  output logic       o_byte_we,
  output logic       o_frame_done,
  output logic       o_result_valid,
  output logic       o_busy
);

  // state    | meaning
  // S_LOAD   | accepting pixels of the current frame
  // S_SETTLE | frame fully shifted in, waiting for classifier logic to settle
  // S_VALID  | classifier result valid; next pixel starts a new frame
  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_VALID} state_t;

  localparam int CW = $clog2(PIXELS);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [3:0]    r_even, w_even_nxt;
  logic [SW-1:0] r_settle, w_settle_nxt;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          r_we, w_we_nxt;
  logic          r_fd, w_fd_nxt;
  logic          r_rv, w_rv_nxt;
  logic          r_busy, w_busy_nxt;
  logic          w_xfer;
  logic          w_last;
  logic [3:0]    w_therm;

  assign w_therm = {i_pix_data > 8'(T3), i_pix_data > 8'(T2),
                    i_pix_data > 8'(T1), i_pix_data > 8'(T0)};

  assign o_pix_ready = !i_reset && (r_state != S_SETTLE);
  assign w_xfer      = i_pix_valid && o_pix_ready;
  assign w_last      = (r_count == CW'(PIXELS - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_even_nxt   = r_even;
    w_settle_nxt = r_settle;
    w_byte_nxt   = r_byte;
    w_we_nxt     = 1'b0;
    w_fd_nxt     = 1'b0;
    w_rv_nxt     = r_rv;
    case (r_state)
      S_LOAD, S_VALID: begin
        if (w_xfer) begin
          w_state_nxt = S_LOAD;
          w_rv_nxt    = 1'b0;
          w_count_nxt = w_last ? '0 : r_count + 1'b1;
          if (!r_count[0]) begin
            w_even_nxt = w_therm;
          end else begin
            w_byte_nxt = {r_even, w_therm};
            w_we_nxt   = 1'b1;
          end
          // PIXELS is even, so the last pixel always completes a byte
          if (w_last) begin
            w_state_nxt  = S_SETTLE;
            w_settle_nxt = SW'(SETTLE_CYCLES);
            w_fd_nxt     = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (r_settle == '0) begin
          w_state_nxt = S_VALID;
          w_rv_nxt    = 1'b1;
        end else begin
          w_settle_nxt = r_settle - 1'b1;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
    w_busy_nxt = ((w_state_nxt == S_LOAD) && (w_count_nxt != '0)) ||
                 (w_state_nxt == S_SETTLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_LOAD;
      r_count  <= '0;
      r_even   <= '0;
      r_settle <= '0;
      r_byte   <= '0;
      r_we     <= 1'b0;
      r_fd     <= 1'b0;
      r_rv     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_even   <= w_even_nxt;
      r_settle <= w_settle_nxt;
      r_byte   <= w_byte_nxt;
      r_we     <= w_we_nxt;
      r_fd     <= w_fd_nxt;
      r_rv     <= w_rv_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign o_byte_out     = r_byte;
  assign o_byte_we      = r_we;
  assign o_frame_done   = r_fd;
  assign o_result_valid = r_rv;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_lgn_pixel_loader.sv
// Bench for lgn_pixel_loader: table vectors for packing, frame-level scoreboard
// against a thermometer reference model, and timing/reset corner sequences.
module tb_lgn_pixel_loader;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_pix_data;
  logic       i_pix_valid;
  logic       o_pix_ready;
  logic [7:0] o_byte_out;
  logic       o_byte_we;
  logic       o_frame_done;
  logic       o_result_valid;
  logic       o_busy;

  lgn_pixel_loader dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_pix_data    (i_pix_data),
    .i_pix_valid   (i_pix_valid),
    .o_pix_ready   (o_pix_ready),
    .o_byte_out    (o_byte_out),
    .o_byte_we     (o_byte_we),
    .o_frame_done  (o_frame_done),
    .o_result_valid(o_result_valid),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         stall_bad = 0;
  int         fd_cnt = 0;
  int         fd_idx = 0;
  int         fd_bad = 0;
  logic [7:0] got[$];
  logic [7:0] pix[256];
  vec_t       tbl[6];

  // Reference: number of thresholds exceeded, expressed as a thermometer code
  function automatic logic [3:0] therm(input logic [7:0] p);
    int n = 0;
    if (p > 8'd51)  n++;
    if (p > 8'd102) n++;
    if (p > 8'd153) n++;
    if (p > 8'd204) n++;
    return 4'((1 << n) - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_byte_we) got.push_back(o_byte_out);
    if (o_frame_done) begin
      fd_cnt++;
      fd_idx = got.size();
      if (!o_byte_we) fd_bad++;
    end
  end

  // Called just after a negedge; returns at the negedge following the transfer.
  task automatic send(input logic [7:0] d, input bit gaps);
    int g = 0;
    int n = 0;
    if (gaps) while ($urandom_range(0, 1) == 1 && g < 8) g++;
    repeat (g) begin
      i_pix_valid = 1'b0;
      i_pix_data  = 8'($urandom);
      @(negedge i_clk);
      if (o_byte_we) stall_bad++;
    end
    i_pix_valid = 1'b1;
    i_pix_data  = d;
    while (!o_pix_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(o_pix_ready), 32'd1);
    @(negedge i_clk);
    i_pix_valid = 1'b0;
    i_pix_data  = 8'($urandom);
  endtask

  task automatic wait_rv();
    int n = 0;
    while (!o_result_valid && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("result_valid_rise", 32'(o_result_valid), 32'd1);
    chk("busy_low_at_valid", 32'(o_busy), 32'd0);
  endtask

  task automatic check_frame();
    chk("byte_count", 32'(got.size()), 32'd128);
    for (int i = 0; i < got.size() && i < 128; i++)
      chk("frame_byte", 32'(got[i]), 32'({therm(pix[2*i]), therm(pix[2*i+1])}));
    chk("frame_done_count", 32'(fd_cnt), 32'd1);
    chk("frame_done_index", 32'(fd_idx), 32'd128);
    chk("frame_done_with_we", 32'(fd_bad), 32'd0);
  endtask

  task automatic clear_log();
    got.delete();
    fd_cnt = 0;
    fd_idx = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'd255, 8'd52,  8'hF1};
    tbl[1] = '{8'd204, 8'd51,  8'h70};
    tbl[2] = '{8'd0,   8'd153, 8'h03};
    tbl[3] = '{8'd102, 8'd103, 8'h13};
    tbl[4] = '{8'd154, 8'd205, 8'h7F};
    tbl[5] = '{8'd53,  8'd152, 8'h13};

    i_reset     = 1'b1;
    i_pix_valid = 1'b0;
    i_pix_data  = 8'd0;
    repeat (3) @(negedge i_clk);
    chk("ready_in_reset", 32'(o_pix_ready), 32'd0);
    i_reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(o_pix_ready), 32'd1);
    chk("reset_byte_out", 32'(o_byte_out), 32'd0);
    chk("reset_byte_we", 32'(o_byte_we), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_result_valid", 32'(o_result_valid), 32'd0);

    // Packing vectors, back-to-back pixels
    clear_log();
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, 1'b0);
      chk("even_no_we", 32'(o_byte_we), 32'd0);
      send(tbl[i].b, 1'b0);
      chk("pair_we", 32'(o_byte_we), 32'd1);
      chk("pair_byte", 32'(o_byte_out), 32'(tbl[i].exp));
      chk("pair_busy", 32'(o_busy), 32'd1);
    end
    @(negedge i_clk);
    chk("byte_out_hold", 32'(o_byte_out), 32'(tbl[5].exp));
    chk("we_pulse_count", 32'(got.size()), 32'd6);

    // Full frame of constant 100 with settle timing
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    clear_log();
    for (int i = 0; i < 256; i++) pix[i] = 8'd100;
    for (int i = 0; i < 256; i++) send(pix[i], 1'b0);
    chk("last_we", 32'(o_byte_we), 32'd1);
    chk("last_frame_done", 32'(o_frame_done), 32'd1);
    chk("last_byte", 32'(o_byte_out), 32'h11);
    chk("ready_low_settle0", 32'(o_pix_ready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge i_clk);
      chk("ready_low_settle", 32'(o_pix_ready), 32'd0);
      chk("rv_low_settle", 32'(o_result_valid), 32'd0);
      chk("busy_settle", 32'(o_busy), 32'd1);
    end
    @(negedge i_clk);
    chk("rv_at_settle_plus1", 32'(o_result_valid), 32'd1);
    chk("busy_fall_with_rv", 32'(o_busy), 32'd0);
    chk("ready_in_valid", 32'(o_pix_ready), 32'd1);
    check_frame();

    // New frame from VALID, random data with random gaps
    clear_log();
    stall_bad = 0;
    for (int i = 0; i < 256; i++) pix[i] = 8'($urandom);
    send(pix[0], 1'b0);
    chk("rv_cleared", 32'(o_result_valid), 32'd0);
    chk("busy_new_frame", 32'(o_busy), 32'd1);
    chk("no_we_pixel0", 32'(o_byte_we), 32'd0);
    for (int i = 1; i < 256; i++) send(pix[i], 1'b1);
    wait_rv();
    check_frame();
    chk("no_we_while_stalled", 32'(stall_bad), 32'd0);

    // Reset in the middle of a frame
    for (int i = 0; i < 77; i++) send(8'($urandom), 1'b0);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("midreset_byte_out", 32'(o_byte_out), 32'd0);
    chk("midreset_we", 32'(o_byte_we), 32'd0);
    chk("midreset_fd", 32'(o_frame_done), 32'd0);
    chk("midreset_rv", 32'(o_result_valid), 32'd0);
    chk("midreset_busy", 32'(o_busy), 32'd0);
    chk("midreset_ready", 32'(o_pix_ready), 32'd0);
    i_reset = 1'b0;
    #1;
    clear_log();
    for (int i = 0; i < 256; i++) pix[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) send(pix[i], 1'b0);
    wait_rv();
    check_frame();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
